serial_uart_receiver: RTL and testbench
=======================================

Name: serial_uart_receiver

Overview:
UART receive engine for the Lab serial link. It consumes the 16x BAUD_SAMPLE_TICK produced by the baud generator and recovers 8N1 (parameterisable) frames from the asynchronous UART_RX line. Each bit is decided by a majority vote of three oversamples taken around mid-bit. Received bytes go to the downstream command parser over a valid/ready handshake, with framing-error and overrun reporting.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first (range 5..9).
SYNC_STAGES, 2, flip-flop stages on UART_RX before use (min 2).
OVERSAMPLE, 16, sample ticks per bit; fixed to match the baud generator x16 tap.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-high.
BAUD_SAMPLE_TICK  in  1  single-CLK pulse at 16x baud rate.
UART_RX  in  1  raw serial line, idle high, asynchronous to CLK.
RX_DATA  out  DATA_BITS  received payload; stable while RX_DATA_VALID=1.
RX_DATA_VALID  out  1  payload available.
RX_DATA_READY  in  1  consumer accepts; transfer occurs on VALID&READY at a rising CLK edge.
RX_FRAME_ERROR  out  1  one-CLK pulse: stop bit decided 0.
RX_OVERRUN  out  1  one-CLK pulse: good frame lost because the previous byte was not consumed.

Behaviour:
- Reset (async, RESET=1): state IDLE; synchroniser regs = 1; sample counter = 0; bit counter = 0; shift reg = 0. RX_DATA = 0; RX_DATA_VALID, RX_FRAME_ERROR and RX_OVERRUN = 0. Reset mid-frame discards the partial frame.
- Synchroniser: UART_RX passes through SYNC_STAGES flops. The edge detector uses the last stage plus one delayed copy (rx_s, rx_d).
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- Sample counter: 4 bits, advances only on BAUD_SAMPLE_TICK and wraps 15->0. Positions 7, 8 and 9 capture rx_s. The bit is decided at the tick where the counter = 9: value = majority of the three samples.
- IDLE: when rx_d=1 and rx_s=0 (falling edge, checked every CLK), clear the sample counter and go to START.
- START: at decision, majority 0 -> DATA with bit counter = 0. Majority 1 -> false start, return to IDLE.
- DATA: at each decision, shift the bit into the MSB of the shift reg (right shift, LSB first) and increment the bit counter. After DATA_BITS decisions -> STOP.
- STOP: at decision:
  - majority 1 -> good frame, go to IDLE immediately. Early resync allows back-to-back frames with no idle gap.
  - majority 0 -> RX_FRAME_ERROR pulse, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1 (covers break conditions), then go to IDLE.
- Latency: RX_DATA and RX_DATA_VALID update on the CLK edge after the BAUD_SAMPLE_TICK cycle containing the stop-bit decision. RX_FRAME_ERROR and RX_OVERRUN pulse on that same edge.
- Output handshake at good frame completion:
  - VALID=0 -> load RX_DATA, set VALID.
  - VALID=1 and READY=1 in the same cycle -> load the new RX_DATA; VALID stays 1; no overrun.
  - VALID=1 and READY=0 -> keep the old RX_DATA, drop the new byte, pulse RX_OVERRUN.
  - Otherwise VALID&READY clears VALID; RX_DATA holds its last value.
- No tick arriving holds all state. The receiver never deadlocks; the only non-IDLE wait without ticks is WAIT_IDLE.

Decomposition:
- Shared package (serial_uart_pkg): receiver state encoding; OVERSAMPLE=16; sample positions 7/8/9 and decision index 9. The transmitter reuses the constants.
- One sub-module: serial_uart_input_sync, a parameterised SYNC_STAGES synchroniser with reset value 1 and a falling-edge output.
- Majority vote, counters and FSM stay in the top.

Test Plan:
Bench drives BAUD_SAMPLE_TICK every 4 CLK, so 1 bit = 64 CLK; the line is driven from the same tick model.
1. Frame 0xA5 8N1, READY=1 -> VALID high for exactly 1 CLK, RX_DATA=0xA5, no error or overrun pulses. Repeat with a 1-tick low glitch at position 8 of bit 0 -> still 0xA5.
2. UART_RX low for 3 ticks then high, followed by 0x3C -> no VALID from the glitch, state returns to IDLE, then RX_DATA=0x3C.
3. 0x55 with stop bit 0, line held low 40 ticks then high, then 0x81 -> one RX_FRAME_ERROR pulse, no VALID for 0x55, then RX_DATA=0x81 valid.
4. READY=0, back-to-back 0x11 and 0x22 -> RX_DATA=0x11 and VALID held; RX_OVERRUN pulses once at the 0x22 stop decision; READY=1 then transfers 0x11 and VALID drops.
5. READY pulsed exactly in the completion cycle of 0x22 while 0x11 is pending -> RX_DATA=0x22, VALID stays 1, no RX_OVERRUN.
6. RESET asserted during bit 4 of 0xF0 -> all outputs 0 asynchronously; after release, frame 0x0F is received correctly with no spurious VALID.

Source files
------------

// File: rtl/serial_uart_pkg.sv
`default_nettype none
//==============================================================================
// Module      : serial_uart_pkg
// Description : Shared constants and types for the Lab serial link UART
//               (receiver state encoding, oversampling ratio, sample points).
// Revision    : 1.0 - initial release
//==============================================================================
package serial_uart_pkg;

   // Sample ticks per bit, matching the baud generator x16 tap
   localparam int unsigned c_oversample   = 16;

   // Mid-bit oversample positions and the decision point
   localparam int unsigned c_sample_pos_a = 7;
   localparam int unsigned c_sample_pos_b = 8;
   localparam int unsigned c_sample_pos_c = 9;
   localparam int unsigned c_decide_pos   = 9;

   // Receiver FSM encoding
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

   // Two-out-of-three vote used to decide each bit
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_uart_receiver_if.sv
`default_nettype none
//==============================================================================
// Module      : serial_uart_receiver_if
// Description : Byte output handshake of the UART receiver towards the
//               command parser, plus framing-error / overrun pulses.
// Revision    : 1.0 - initial release
//==============================================================================
interface serial_uart_receiver_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] RX_DATA;
   logic                 RX_DATA_VALID;
   logic                 RX_DATA_READY;
   logic                 RX_FRAME_ERROR;
   logic                 RX_OVERRUN;

   // Receiver side: produces bytes and status pulses
   modport master (
      output RX_DATA,
      output RX_DATA_VALID,
      output RX_FRAME_ERROR,
      output RX_OVERRUN,
      input  RX_DATA_READY
   );

   // Consumer side: accepts bytes
   modport slave (
      input  RX_DATA,
      input  RX_DATA_VALID,
      input  RX_FRAME_ERROR,
      input  RX_OVERRUN,
      output RX_DATA_READY
   );
endinterface
`default_nettype wire

// File: rtl/serial_uart_input_sync.sv
`default_nettype none
//==============================================================================
// Module      : serial_uart_input_sync
// Description : Multi-stage synchroniser for the asynchronous UART line with
//               idle-high reset value and a falling-edge detect output.
// Revision    : 1.0 - initial release
//==============================================================================
module serial_uart_input_sync #(
   parameter int SYNC_STAGES = 2
)(
   input  logic CLK,
   input  logic RESET,
   input  logic i_rx_async,
   output logic o_rx_s,
   output logic o_rx_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_rx_d;

   // Shift the raw line through the synchroniser and keep one delayed copy
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sync <= '1;
         r_rx_d <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx_async};
         r_rx_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_rx_s    = r_sync[SYNC_STAGES-1];
   assign o_rx_fall = r_rx_d & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/serial_uart_receiver.sv
`default_nettype none
//==============================================================================
// Module      : serial_uart_receiver
// Description : 16x oversampling UART receive engine with 3-sample majority
//               vote, valid/ready byte output, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
//==============================================================================
module serial_uart_receiver
   import serial_uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int OVERSAMPLE  = c_oversample
)(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   BAUD_SAMPLE_TICK,
   input  logic                   UART_RX,
   serial_uart_receiver_if.master rx_if
);

   localparam int CNT_W     = $clog2(OVERSAMPLE);
   localparam int BIT_CNT_W = 4;

   localparam logic [CNT_W-1:0]     c_pos_a    = CNT_W'(c_sample_pos_a);
   localparam logic [CNT_W-1:0]     c_pos_b    = CNT_W'(c_sample_pos_b);
   localparam logic [CNT_W-1:0]     c_pos_dec  = CNT_W'(c_decide_pos);
   localparam logic [BIT_CNT_W-1:0] c_last_bit = BIT_CNT_W'(DATA_BITS - 1);

   rx_state_t              r_state;
   rx_state_t              w_state_next;
   logic                   w_rx_s;
   logic                   w_rx_fall;
   logic [CNT_W-1:0]       r_sample_cnt;
   logic [BIT_CNT_W-1:0]   r_bit_cnt;
   logic                   r_samp_a;
   logic                   r_samp_b;
   logic [DATA_BITS-1:0]   r_shift;
   logic [DATA_BITS-1:0]   r_rx_data;
   logic                   r_rx_valid;
   logic                   r_frame_error;
   logic                   r_overrun;
   logic                   w_decide;
   logic                   w_bit;
   logic                   w_good_frame;
   logic                   w_bad_frame;

   serial_uart_input_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_input_sync (
      .CLK        (CLK),
      .RESET      (RESET),
      .i_rx_async (UART_RX),
      .o_rx_s     (w_rx_s),
      .o_rx_fall  (w_rx_fall)
   );

   // The third vote is the live synchronised value at the decision tick
   assign w_decide     = BAUD_SAMPLE_TICK && (r_sample_cnt == c_pos_dec);
   assign w_bit        = majority3(r_samp_a, r_samp_b, w_rx_s);
   assign w_good_frame = (r_state == ST_STOP) && w_decide && w_bit;
   assign w_bad_frame  = (r_state == ST_STOP) && w_decide && !w_bit;

   // FSM state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:      if (w_rx_fall) w_state_next = ST_START;
         ST_START:     if (w_decide)  w_state_next = w_bit ? ST_IDLE : ST_DATA;
         ST_DATA:      if (w_decide && (r_bit_cnt == c_last_bit)) w_state_next = ST_STOP;
         ST_STOP:      if (w_decide)  w_state_next = w_bit ? ST_IDLE : ST_WAIT_IDLE;
         ST_WAIT_IDLE: if (w_rx_s)    w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase
   end

   // Sample counter, mid-bit samples, bit counter and payload shifter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_samp_a     <= 1'b1;
         r_samp_b     <= 1'b1;
         r_shift      <= '0;
      end else begin
         if ((r_state == ST_IDLE) && w_rx_fall)
            r_sample_cnt <= '0;
         else if (BAUD_SAMPLE_TICK)
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);

         if (BAUD_SAMPLE_TICK && (r_sample_cnt == c_pos_a)) r_samp_a <= w_rx_s;
         if (BAUD_SAMPLE_TICK && (r_sample_cnt == c_pos_b)) r_samp_b <= w_rx_s;

         if ((r_state == ST_START) && w_decide)
            r_bit_cnt <= '0;
         else if ((r_state == ST_DATA) && w_decide) begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
         end
      end
   end

   // Output byte register, valid/ready handshake and status pulses
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_frame_error <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_frame_error <= w_bad_frame;
         r_overrun     <= 1'b0;
         if (w_good_frame) begin
            if (!r_rx_valid || rx_if.RX_DATA_READY) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun  <= 1'b1;
            end
         end else if (r_rx_valid && rx_if.RX_DATA_READY) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_if.RX_DATA        = r_rx_data;
   assign rx_if.RX_DATA_VALID  = r_rx_valid;
   assign rx_if.RX_FRAME_ERROR = r_frame_error;
   assign rx_if.RX_OVERRUN     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_uart_receiver.sv
`default_nettype none
//==============================================================================
// Module      : tb_serial_uart_receiver
// Description : Self-checking bench for serial_uart_receiver; bytes are
//               scoreboarded when sent and compared when handed over.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_serial_uart_receiver;

   logic       CLK     = 1'b0;
   logic       RESET   = 1'b1;
   logic       UART_RX = 1'b1;
   logic [1:0] tick_div = 2'd0;
   logic       BAUD_SAMPLE_TICK;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int valid_cyc = 0;
   int fe_cnt    = 0;
   int ov_cnt    = 0;

   serial_uart_receiver_if #(.DATA_BITS(8)) rx_if();

   serial_uart_receiver #(
      .DATA_BITS   (8),
      .SYNC_STAGES (2),
      .OVERSAMPLE  (16)
   ) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .BAUD_SAMPLE_TICK (BAUD_SAMPLE_TICK),
      .UART_RX          (UART_RX),
      .rx_if            (rx_if)
   );

   always #5 CLK = ~CLK;

   // One sample tick every 4 CLK
   always @(posedge CLK) tick_div <= tick_div + 2'd1;
   assign BAUD_SAMPLE_TICK = (tick_div == 2'd3);

   // Monitor: count status activity and capture every handed-over byte
   always @(negedge CLK) begin
      if (rx_if.RX_DATA_VALID)  valid_cyc++;
      if (rx_if.RX_FRAME_ERROR) fe_cnt++;
      if (rx_if.RX_OVERRUN)     ov_cnt++;
      if (rx_if.RX_DATA_VALID && rx_if.RX_DATA_READY) got_q.push_back(rx_if.RX_DATA);
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Return just after the n-th following sample-tick edge
   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(negedge CLK); while (!BAUD_SAMPLE_TICK);
         @(posedge CLK);
         #1;
      end
   endtask

   // Start bit and LSB-first payload; optional 1-tick low glitch at bit-0 position 8
   task automatic drive_start_data(input logic [7:0] data, input bit glitch);
      UART_RX = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         UART_RX = data[i];
         if (glitch && i == 0) begin
            wait_ticks(8);
            UART_RX = 1'b0;
            wait_ticks(1);
            UART_RX = data[i];
            wait_ticks(7);
         end else begin
            wait_ticks(16);
         end
      end
   endtask

   task automatic drive_stop(input logic stop_bit, input int ticks);
      UART_RX = stop_bit;
      wait_ticks(ticks);
      UART_RX = 1'b1;
   endtask

   task automatic check_scoreboard(input string name);
      logic [7:0] got;
      logic [7:0] exp;
      while (got_q.size() > 0) begin
         got = got_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected byte %h handed over, none expected", name, got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL %s: byte got %h expected %h", name, got, exp);
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected byte(s) never delivered (got 0)", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      UART_RX = 1'b1;
      rx_if.RX_DATA_READY = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      checks++; if (rx_if.RX_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_if.RX_DATA); end
      checks++; if (rx_if.RX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_if.RX_DATA_VALID); end
      checks++; if (rx_if.RX_FRAME_ERROR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", rx_if.RX_FRAME_ERROR); end
      checks++; if (rx_if.RX_OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", rx_if.RX_OVERRUN); end
      RESET = 1'b0;
      wait_ticks(4);
   endtask

   task automatic test_basic_frame();
      int v0, f0, o0;
      rx_if.RX_DATA_READY = 1'b1;
      for (int g = 0; g < 2; g++) begin
         v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
         exp_q.push_back(8'hA5);
         drive_start_data(8'hA5, g == 1);
         drive_stop(1'b1, 16);
         wait_ticks(4);
         checks++; if (valid_cyc - v0 != 1) begin errors++; $display("FAIL basic_valid_len[%0d]: valid cycles %0d expected 1", g, valid_cyc - v0); end
         checks++; if (fe_cnt != f0) begin errors++; $display("FAIL basic_ferr[%0d]: pulses %0d expected 0", g, fe_cnt - f0); end
         checks++; if (ov_cnt != o0) begin errors++; $display("FAIL basic_ovr[%0d]: pulses %0d expected 0", g, ov_cnt - o0); end
         check_scoreboard(g == 1 ? "basic_glitch" : "basic");
      end
   endtask

   task automatic test_false_start();
      int v0;
      rx_if.RX_DATA_READY = 1'b1;
      v0 = valid_cyc;
      UART_RX = 1'b0;
      wait_ticks(3);
      UART_RX = 1'b1;
      wait_ticks(20);
      checks++; if (valid_cyc != v0) begin errors++; $display("FAIL false_start_valid: valid cycles %0d expected 0", valid_cyc - v0); end
      exp_q.push_back(8'h3C);
      drive_start_data(8'h3C, 1'b0);
      drive_stop(1'b1, 16);
      wait_ticks(4);
      check_scoreboard("false_start_then_3c");
   endtask

   task automatic test_frame_error();
      int v0, f0, o0;
      rx_if.RX_DATA_READY = 1'b1;
      v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt;
      drive_start_data(8'h55, 1'b0);
      drive_stop(1'b0, 40);
      wait_ticks(20);
      checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulse: pulses %0d expected 1", fe_cnt - f0); end
      checks++; if (valid_cyc != v0) begin errors++; $display("FAIL ferr_no_valid: valid cycles %0d expected 0", valid_cyc - v0); end
      exp_q.push_back(8'h81);
      drive_start_data(8'h81, 1'b0);
      drive_stop(1'b1, 16);
      wait_ticks(4);
      checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL ferr_after_81: pulses %0d expected 1", fe_cnt - f0); end
      checks++; if (ov_cnt != o0) begin errors++; $display("FAIL ferr_ovr: pulses %0d expected 0", ov_cnt - o0); end
      check_scoreboard("ferr_then_81");
   endtask

   task automatic test_back_to_back_overrun();
      int o0;
      rx_if.RX_DATA_READY = 1'b0;
      o0 = ov_cnt;
      exp_q.push_back(8'h11);
      drive_start_data(8'h11, 1'b0);
      drive_stop(1'b1, 16);
      drive_start_data(8'h22, 1'b0);
      drive_stop(1'b1, 16);
      wait_ticks(2);
      checks++; if (rx_if.RX_DATA_VALID !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx_if.RX_DATA_VALID); end
      checks++; if (rx_if.RX_DATA !== 8'h11) begin errors++; $display("FAIL ovr_data_kept: got %h expected 11", rx_if.RX_DATA); end
      checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse: pulses %0d expected 1", ov_cnt - o0); end
      rx_if.RX_DATA_READY = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (rx_if.RX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b expected 0", rx_if.RX_DATA_VALID); end
      checks++; if (rx_if.RX_DATA !== 8'h11) begin errors++; $display("FAIL ovr_data_hold: got %h expected 11", rx_if.RX_DATA); end
      check_scoreboard("back_to_back");
   endtask

   task automatic test_ready_in_completion();
      int o0;
      rx_if.RX_DATA_READY = 1'b0;
      o0 = ov_cnt;
      exp_q.push_back(8'h11);
      drive_start_data(8'h11, 1'b0);
      drive_stop(1'b1, 16);
      exp_q.push_back(8'h22);
      drive_start_data(8'h22, 1'b0);
      UART_RX = 1'b1;
      wait_ticks(9);
      // Raise READY only for the cycle holding the stop-bit decision tick
      do @(negedge CLK); while (tick_div != 2'd2);
      @(posedge CLK);
      #1 rx_if.RX_DATA_READY = 1'b1;
      @(negedge CLK);
      checks++; if (rx_if.RX_DATA_VALID !== 1'b1 || rx_if.RX_DATA !== 8'h11) begin
         errors++; $display("FAIL pulse_pending: valid %b data %h expected 1 11", rx_if.RX_DATA_VALID, rx_if.RX_DATA); end
      @(posedge CLK);
      #1 rx_if.RX_DATA_READY = 1'b0;
      checks++; if (rx_if.RX_DATA !== 8'h22) begin errors++; $display("FAIL pulse_data: got %h expected 22", rx_if.RX_DATA); end
      checks++; if (rx_if.RX_DATA_VALID !== 1'b1) begin errors++; $display("FAIL pulse_valid: got %b expected 1", rx_if.RX_DATA_VALID); end
      checks++; if (rx_if.RX_OVERRUN !== 1'b0) begin errors++; $display("FAIL pulse_ovr_now: got %b expected 0", rx_if.RX_OVERRUN); end
      wait_ticks(6);
      checks++; if (ov_cnt != o0) begin errors++; $display("FAIL pulse_ovr: pulses %0d expected 0", ov_cnt - o0); end
      rx_if.RX_DATA_READY = 1'b1;
      wait_ticks(2);
      check_scoreboard("ready_in_completion");
   endtask

   task automatic test_reset_midframe();
      int v0;
      rx_if.RX_DATA_READY = 1'b0;
      drive_start_data(8'h5A, 1'b0);
      drive_stop(1'b1, 16);
      wait_ticks(2);
      checks++; if (rx_if.RX_DATA_VALID !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", rx_if.RX_DATA_VALID); end
      UART_RX = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         UART_RX = 1'b0;
         wait_ticks(16);
      end
      UART_RX = 1'b1;
      wait_ticks(5);
      #2 RESET = 1'b1;
      #1;
      checks++; if (rx_if.RX_DATA !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h expected 00", rx_if.RX_DATA); end
      checks++; if (rx_if.RX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", rx_if.RX_DATA_VALID); end
      checks++; if (rx_if.RX_FRAME_ERROR !== 1'b0 || rx_if.RX_OVERRUN !== 1'b0) begin
         errors++; $display("FAIL rst_async_pulses: ferr %b ovr %b expected 0 0", rx_if.RX_FRAME_ERROR, rx_if.RX_OVERRUN); end
      repeat (3) @(posedge CLK);
      #3 RESET = 1'b0;
      rx_if.RX_DATA_READY = 1'b1;
      v0 = valid_cyc;
      wait_ticks(20);
      checks++; if (valid_cyc != v0) begin errors++; $display("FAIL rst_spurious_valid: valid cycles %0d expected 0", valid_cyc - v0); end
      exp_q.push_back(8'h0F);
      drive_start_data(8'h0F, 1'b0);
      drive_stop(1'b1, 16);
      wait_ticks(4);
      checks++; if (valid_cyc - v0 != 1) begin errors++; $display("FAIL rst_0f_valid: valid cycles %0d expected 1", valid_cyc - v0); end
      check_scoreboard("reset_then_0f");
   endtask

   initial begin
      rx_if.RX_DATA_READY = 1'b0;
      test_reset();
      test_basic_frame();
      test_false_start();
      test_frame_error();
      test_back_to_back_overrun();
      test_ready_in_completion();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
